// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared types and widths for the unified-memory arbiter.
//   arb_state_t - arbiter FSM states (idle / access in flight / response)
//   arb_owner_t - which requester owns the current access
//   ADDR_W_DEF / DATA_W_DEF - default bus widths
//   LAT_W / CNT_W - widths of the latency and starvation counters (limits 1..15)
package mips_mem_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int LAT_W      = 4;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_WAIT,
        ARB_RESP
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_D
    } arb_owner_t;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// mem_arb_starve_ctr: saturating count of data grants made while a fetch waits.
//   CLK        - clock
//   Reset_L    - synchronous active-low reset
//   inc_i      - count one data grant (ignored once saturated)
//   clr_i      - restart from zero; wins over inc_i
//   at_limit_o - count has reached STARVE_LIMIT, fetch must win next
module mem_arb_starve_ctr
    import mips_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic CLK,
    input  logic Reset_L,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_limit_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign at_limit_o = (cnt_q == CNT_W'(STARVE_LIMIT));

    always_comb begin
        cnt_d = clr_i ? '0 : (inc_i & ~at_limit_o) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge CLK) begin
        if (!Reset_L) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: shares one single-ported memory between instruction fetch
// and the data stage, one access at a time, with fixed memory latency.
//   CLK, Reset_L              - clock, synchronous active-low reset
//   if_req/if_addr            - fetch request (held until if_rvalid)
//   if_rvalid/if_rdata        - one-cycle fetch response
//   d_req/d_we/d_addr/d_wdata - data request (held until d_rvalid)
//   d_rvalid/d_rdata          - one-cycle data response (rdata 0 for stores)
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata - memory port
//   stall_if/stall_mem        - pipeline stall lines
//   busy                      - arbiter not idle
module mips_mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              Reset_L,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              busy
);

    arb_state_t        state_q, state_d;
    arb_owner_t        owner_q, owner_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic idle, at_limit, gnt_data, gnt_fetch, starve_inc, starve_clr;

    assign idle = (state_q == ARB_IDLE);

    // Data wins unless a fetch has already been passed over STARVE_LIMIT times.
    assign gnt_data   = d_req & (~if_req | ~at_limit);
    assign gnt_fetch  = if_req & ~gnt_data;
    assign starve_inc = idle & gnt_data & if_req;
    assign starve_clr = idle & (~if_req | gnt_fetch);

    mem_arb_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .CLK       (CLK),
        .Reset_L   (Reset_L),
        .inc_i     (starve_inc),
        .clr_i     (starve_clr),
        .at_limit_o(at_limit)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        lat_d       = lat_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (if_req | d_req) begin
                    state_d     = ARB_WAIT;
                    owner_d     = gnt_data ? OWN_D : OWN_IF;
                    lat_d       = LAT_W'(MEM_LATENCY);
                    mem_en_d    = 1'b1;
                    mem_we_d    = gnt_data & d_we;
                    mem_addr_d  = gnt_data ? d_addr : if_addr;
                    mem_wdata_d = gnt_data ? d_wdata : '0;
                end
            end
            ARB_WAIT: begin
                // Counter reaches zero exactly when mem_rdata is valid.
                if (lat_q == '0) begin
                    state_d = ARB_RESP;
                    if (owner_q == OWN_IF) begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = mem_rdata;
                    end else begin
                        d_rvalid_d = 1'b1;
                        d_rdata_d  = mem_we_q ? '0 : mem_rdata;
                    end
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
                owner_d = OWN_NONE;
            end
            default: begin
                state_d = ARB_IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!Reset_L) begin
            state_q     <= ARB_IDLE;
            owner_q     <= OWN_NONE;
            lat_q       <= '0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lat_q       <= lat_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign if_rvalid = if_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign stall_if  = if_req & ~if_rvalid_q;
    assign stall_mem = d_req & ~d_rvalid_q;
    assign busy      = ~idle;

endmodule
